// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command sequencer: state encoding,
// DCS opcodes, init ROM entry layout and the address-window word helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DELAY,
    ST_READY,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIXEL
  } state_e;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_PASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  // ROM entry = {is_delay, dc, byte}
  localparam int ROM_DLY_BIT  = 9;
  localparam int ROM_DC_BIT   = 8;
  localparam int ROM_BYTE_MSB = 7;
  localparam int ROM_BYTE_LSB = 0;
  localparam logic [9:0] ROM_END = 10'h3FF;

  // Word 'idx' of a CASET/PASET burst: opcode, lo[8], lo[7:0], hi[8], hi[7:0].
  function automatic logic [8:0] addr_word(input logic [7:0] op,
                                           input logic [8:0] lo,
                                           input logic [8:0] hi,
                                           input logic [2:0] idx);
    logic [8:0] w;
    case (idx)
      3'd0:    w = {1'b0, op};
      3'd1:    w = {1'b1, 7'd0, lo[8]};
      3'd2:    w = {1'b1, lo[7:0]};
      3'd3:    w = {1'b1, 7'd0, hi[8]};
      default: w = {1'b1, hi[7:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel power-up table; entries beyond the programmed sequence read as the end marker.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [5:0] idx_i,
  output logic [9:0] entry_o
);

  always_comb begin
    entry_o = ROM_END;
    case (idx_i)
      6'd0:    entry_o = 10'h001;  // software reset
      6'd1:    entry_o = 10'h205;  // wait 5 ticks
      6'd2:    entry_o = 10'h011;  // sleep out
      6'd3:    entry_o = 10'h200;  // zero-length wait
      6'd4:    entry_o = 10'h03A;
      6'd5:    entry_o = 10'h155;  // 16 bpp
      6'd6:    entry_o = 10'h036;
      6'd7:    entry_o = 10'h148;
      6'd8:    entry_o = 10'h029;  // display on
      default: entry_o = ROM_END;
    endcase
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: runs the init ROM, then turns rectangle fill requests
// into CASET/PASET/RAMWR + pixel words. Define LCD_INIT_DELAY_EN to honour ROM delays.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int DELAY_UNIT = 100000,
  parameter int INIT_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_full,
  output logic [8:0]  cmd_dout,
  output logic        cmd_wr,
  input  logic        fill_req,
  input  logic [8:0]  fill_x0,
  input  logic [8:0]  fill_x1,
  input  logic [8:0]  fill_y0,
  input  logic [8:0]  fill_y1,
  input  logic [15:0] fill_color,
  output logic        ready,
  output logic        fill_done,
  output logic        fill_err
);

  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);

  state_e           state_q;
  logic [6:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [8:0]       x0_q, x1_q, y0_q, y1_q;
  logic [15:0]      color_q;
  logic [2:0]       sub_q;
  logic             phase_q, last_q;
  logic [16:0]      pix_q;
  logic [8:0]       word_q;
  logic             vld_q, done_q, err_q;

  logic [9:0]       rom_entry;
  logic [16:0]      w_d, h_d, npix_d;
  logic             adv;

  lcd_init_rom u_rom (
    .idx_i   (idx_q[5:0]),
    .entry_o (rom_entry)
  );

  always_comb begin
    w_d    = 17'(fill_x1) - 17'(fill_x0) + 17'd1;
    h_d    = 17'(fill_y1) - 17'(fill_y0) + 17'd1;
    npix_d = w_d * h_d;
  end

  // The one-word output slot may take a new word when empty or drained this cycle.
  assign adv = ~vld_q | ~cmd_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      sub_q   <= '0;
      phase_q <= 1'b0;
      last_q  <= 1'b0;
      pix_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (~cmd_full) vld_q <= 1'b0;

      case (state_q)
        ST_INIT: begin
          if (adv) begin
            if (idx_q == 7'(INIT_LEN) || rom_entry == ROM_END) begin
              state_q <= ST_READY;
            end else begin
              idx_q <= idx_q + 7'd1;
              if (rom_entry[ROM_DLY_BIT]) begin
`ifdef LCD_INIT_DELAY_EN
                if (rom_entry[ROM_BYTE_MSB:ROM_BYTE_LSB] != 8'd0) begin
                  cnt_q   <= CNT_W'(int'(rom_entry[ROM_BYTE_MSB:ROM_BYTE_LSB]) * DELAY_UNIT - 1);
                  state_q <= ST_DELAY;
                end
`endif
              end else begin
                word_q <= rom_entry[ROM_DC_BIT:0];
                vld_q  <= 1'b1;
              end
            end
          end
        end

        ST_DELAY: begin
          if (cnt_q == '0) state_q <= ST_INIT;
          else             cnt_q   <= cnt_q - 1'b1;
        end

        ST_READY: begin
          if (fill_req) begin
            x0_q    <= fill_x0;
            x1_q    <= fill_x1;
            y0_q    <= fill_y0;
            y1_q    <= fill_y1;
            color_q <= fill_color;
            if (fill_x1 < fill_x0 || fill_y1 < fill_y0) begin
              err_q <= 1'b1;
            end else begin
              pix_q   <= npix_d;
              sub_q   <= '0;
              phase_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= ST_CASET;
            end
          end
        end

        ST_CASET: begin
          if (adv) begin
            word_q <= addr_word(OP_CASET, x0_q, x1_q, sub_q);
            vld_q  <= 1'b1;
            if (sub_q == 3'd4) begin
              sub_q   <= '0;
              state_q <= ST_PASET;
            end else begin
              sub_q <= sub_q + 3'd1;
            end
          end
        end

        ST_PASET: begin
          if (adv) begin
            word_q <= addr_word(OP_PASET, y0_q, y1_q, sub_q);
            vld_q  <= 1'b1;
            if (sub_q == 3'd4) begin
              sub_q   <= '0;
              state_q <= ST_RAMWR;
            end else begin
              sub_q <= sub_q + 3'd1;
            end
          end
        end

        ST_RAMWR: begin
          if (adv) begin
            word_q  <= {1'b0, OP_RAMWR};
            vld_q   <= 1'b1;
            state_q <= ST_PIXEL;
          end
        end

        ST_PIXEL: begin
          // last_q: final byte is sitting in the slot; finish once it drains.
          if (last_q) begin
            if (~cmd_full) begin
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_READY;
            end
          end else if (adv) begin
            vld_q <= 1'b1;
            if (!phase_q) begin
              word_q  <= {1'b1, color_q[15:8]};
              phase_q <= 1'b1;
            end else begin
              word_q  <= {1'b1, color_q[7:0]};
              phase_q <= 1'b0;
              if (pix_q == 17'd1) last_q <= 1'b1;
              else                pix_q  <= pix_q - 17'd1;
            end
          end
        end

        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign cmd_dout  = word_q;
  assign cmd_wr    = vld_q & ~cmd_full & ~rst;
  assign ready     = (state_q == ST_READY);
  assign fill_done = done_q;
  assign fill_err  = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: expected FIFO words come from the init table
// and fill arithmetic; random back-pressure, errors and mid-fill reset.
module tb_lcd_cmd_seq;

  localparam int DU = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_full = 1'b0;
  logic        fill_req = 1'b0;
  logic [8:0]  fill_x0 = '0, fill_x1 = '0, fill_y0 = '0, fill_y1 = '0;
  logic [15:0] fill_color = '0;
  logic [8:0]  cmd_dout;
  logic        cmd_wr, ready, fill_done, fill_err;

  lcd_cmd_seq #(.DELAY_UNIT(DU), .INIT_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_full   (cmd_full),
    .cmd_dout   (cmd_dout),
    .cmd_wr     (cmd_wr),
    .fill_req   (fill_req),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .ready      (ready),
    .fill_done  (fill_done),
    .fill_err   (fill_err)
  );

  always #5 clk = ~clk;

  // Independent copy of the panel init table: {is_delay, dc, byte}.
  int rom_tbl [10] = '{10'h001, 10'h205, 10'h011, 10'h200, 10'h03A,
                       10'h155, 10'h036, 10'h148, 10'h029, 10'h3FF};

  int         cmp = 0, bad = 0, cyc = 0;
  int         wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         wr_cyc [$];
  logic [8:0] exp_q [$];
  bit         full_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    cmp++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_init();
    for (int i = 0; i < 10; i++) begin
      if (rom_tbl[i] == 10'h3FF) break;
      if (((rom_tbl[i] >> 9) & 1) == 0) exp_q.push_back(9'(rom_tbl[i] & 10'h1FF));
    end
  endfunction

  function automatic int push_fill(input int x0, input int x1, input int y0,
                                   input int y1, input int col);
    int n;
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'(9'h100 | (x0 >> 8)));
    exp_q.push_back(9'(9'h100 | (x0 & 255)));
    exp_q.push_back(9'(9'h100 | (x1 >> 8)));
    exp_q.push_back(9'(9'h100 | (x1 & 255)));
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'(9'h100 | (y0 >> 8)));
    exp_q.push_back(9'(9'h100 | (y0 & 255)));
    exp_q.push_back(9'(9'h100 | (y1 >> 8)));
    exp_q.push_back(9'(9'h100 | (y1 & 255)));
    exp_q.push_back(9'h02C);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(9'(9'h100 | ((col >> 8) & 255)));
      exp_q.push_back(9'(9'h100 | (col & 255)));
    end
    return n;
  endfunction

  // Back-pressure changes just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    cmd_full = full_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Single compare process: every accepted word against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (fill_done) begin
      done_cnt++;
      chk("done_before_last_word", exp_q.size(), 0);
    end
    if (fill_err) err_cnt++;
    if (cmd_wr) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      chk("wr_while_full", int'(cmd_full), 0);
      if (exp_q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_write: got 0x%0h expected no write (cycle %0d)", cmd_dout, cyc);
      end else begin
        chk("word", int'(cmd_dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_ready(input string name, input int lim);
    int n;
    n = 0;
    while (!ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(ready), 1);
  endtask

  task automatic do_fill(input int x0, input int x1, input int y0, input int y1,
                         input int col, input int n, input bit stray);
    int d0, w0, k;
    d0 = done_cnt;
    w0 = wr_cnt;
    fill_x0 = 9'(x0); fill_x1 = 9'(x1); fill_y0 = 9'(y0); fill_y1 = 9'(y1);
    fill_color = 16'(col);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    chk("busy_after_req", int'(ready), 0);
    k = 0;
    while (!fill_done && k < 20000) begin
      @(negedge clk);
      k++;
      if (stray && k == 4) begin
        fill_x0 = 9'd1; fill_x1 = 9'd2; fill_y0 = 9'd1; fill_y1 = 9'd2;
        fill_req = 1'b1;
      end
      if (stray && k == 5) fill_req = 1'b0;
    end
    chk("fill_done_seen", int'(fill_done), 1);
    chk("ready_with_done", int'(ready), 1);
    chk("words_left_at_done", exp_q.size(), 0);
    chk("fill_word_count", wr_cnt - w0, 11 + 2 * n);
    @(negedge clk);
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("done_cleared", int'(fill_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, n, x0, y0, w, h, col, e0, k;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_wr", int'(cmd_wr), 0);
    chk("rst_cmd_dout", int'(cmd_dout), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fill_done", int'(fill_done), 0);
    chk("rst_fill_err", int'(fill_err), 0);

    // Init sequence
    wr_cnt = 0;
    wr_cyc.delete();
    push_init();
    rst = 1'b0;
    wait_ready("init_ready", 3000);
    chk("init_words_left", exp_q.size(), 0);
    chk("init_write_count", wr_cnt, 7);
    if (wr_cyc.size() >= 2) begin
      g = wr_cyc[1] - wr_cyc[0] - 1;
`ifdef LCD_INIT_DELAY_EN
      chk("delay_gap_in_range", int'(g >= 5 * DU && g <= 5 * DU + 4), 1);
`else
      chk("skip_gap_short", int'(g <= 3), 1);
`endif
    end else begin
      chk("init_writes_logged", wr_cyc.size(), 2);
    end

    // Hand-computed fill: 2x2 red
    exp_q = '{9'h02A, 9'h100, 9'h103, 9'h100, 9'h104,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C,
              9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
    do_fill(3, 4, 0, 1, 16'hF800, 4, 1'b0);

    // Same fill under random back-pressure, model-driven
    full_en = 1'b1;
    n = push_fill(3, 4, 0, 1, 16'hF800);
    do_fill(3, 4, 0, 1, 16'hF800, n, 1'b1);

    // Rejected request: x1 < x0
    e0 = err_cnt;
    fill_x0 = 9'd10; fill_x1 = 9'd5; fill_y0 = 9'd0; fill_y1 = 9'd0;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    chk("err_pulse", int'(fill_err), 1);
    chk("err_ready_kept", int'(ready), 1);
    @(negedge clk);
    chk("err_one_cycle", int'(fill_err), 0);
    repeat (6) @(negedge clk);
    chk("err_ready_stays", int'(ready), 1);
    chk("err_count", err_cnt - e0, 1);

    // Rejected request: y1 < y0
    fill_x0 = 9'd0; fill_x1 = 9'd0; fill_y0 = 9'd200; fill_y1 = 9'd199;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    chk("err_y_pulse", int'(fill_err), 1);
    @(negedge clk);

    // Single-pixel boundary at the far corner
    n = push_fill(319, 319, 239, 239, 16'h07E0);
    do_fill(319, 319, 239, 239, 16'h07E0, n, 1'b0);

    // Random rectangles
    for (int i = 0; i < 8; i++) begin
      x0 = $urandom_range(0, 310);
      w = $urandom_range(0, 4);
      y0 = $urandom_range(0, 230);
      h = $urandom_range(0, 3);
      col = $urandom_range(0, 16'hFFFF);
      n = push_fill(x0, x0 + w, y0, y0 + h, col);
      do_fill(x0, x0 + w, y0, y0 + h, col, n, i[0]);
    end

    // Reset during pixel stream
    n = push_fill(0, 19, 0, 9, 16'h1234);
    fill_x0 = 9'd0; fill_x1 = 9'd19; fill_y0 = 9'd0; fill_y1 = 9'd9;
    fill_color = 16'h1234;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    k = 0;
    while (exp_q.size() > 300 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_pixel_phase", int'(exp_q.size() <= 300), 1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_write", int'(cmd_wr), 0);
      chk("rst_not_ready", int'(ready), 0);
    end
    exp_q.delete();
    wr_cnt = 0;
    push_init();
    rst = 1'b0;
    wait_ready("reinit_ready", 3000);
    chk("reinit_words_left", exp_q.size(), 0);
    chk("reinit_write_count", wr_cnt, 7);

    // One more fill after restart
    n = push_fill(100, 102, 50, 51, 16'hABCD);
    do_fill(100, 102, 50, 51, 16'hABCD, n, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter DELAY_UNIT, default 100000, clk cycles per init-delay tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter INIT_LEN, default 64, number of init ROM entries.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports:
- cmd_full  in  1  downstream FIFO full.
- cmd_dout  out  9  FIFO word; bit 8 = D/C (0 command, 1 data), bits 7:0 = byte.
- cmd_wr  out  1  FIFO write strobe.
REQ-005 SHALL have ports:
- fill_req  in  1  rectangle fill request.
- fill_x0, fill_x1  in  9  column bounds, inclusive.
- fill_y0, fill_y1  in  9  row bounds, inclusive.
- fill_color  in  16  RGB565 colour.
REQ-006 SHALL have ports:
- ready  out  1  idle and accepting requests.
- fill_done  out  1  one-cycle pulse after last pixel byte is written.
- fill_err  out  1  one-cycle pulse on rejected request.

Function
REQ-007 SHALL assert cmd_wr at most once per cycle, only when cmd_full=0; cmd_dout is valid in the same cycle.
REQ-008 SHALL hold the current word and not advance while cmd_full=1; no word is dropped or duplicated.
REQ-009 SHALL implement states: INIT, DELAY, READY, CASET, PASET, RAMWR, PIXEL.
REQ-010 INIT SHALL step through init ROM entries in order; each entry is {is_delay, dc, byte}.
- Non-delay entry: written to the FIFO as {dc, byte}.
- Delay entry: enters DELAY for byte*DELAY_UNIT cycles, then returns to INIT at the next entry.
- A delay entry with byte 0 is a no-op.
REQ-011 After the last entry (index INIT_LEN-1 or end marker 0x3FF), the block SHALL go to READY; ready=1 only in READY.
REQ-012 In READY, fill_req=1 SHALL latch all fill_* inputs in that cycle. fill_req outside READY SHALL be ignored.
REQ-013 SHALL reject a request with x1<x0 or y1<y0: pulse fill_err the next cycle, stay in READY, write nothing.
REQ-014 CASET SHALL write {0,0x2A}, {1,x0[8]}, {1,x0[7:0]}, {1,x1[8]}, {1,x1[7:0]}. PASET SHALL write the same sequence with 0x2B and y0/y1.
REQ-015 RAMWR SHALL write {0,0x2C}. PIXEL SHALL then write N pixels as {1,color[15:8]} then {1,color[7:0]}, where N=(x1-x0+1)*(y1-y0+1) is computed 17 bits wide (max 76800).
REQ-016 A single-pixel rectangle (x0=x1, y0=y1) SHALL produce exactly 2 pixel bytes.
REQ-017 After the final pixel byte is accepted, the block SHALL pulse fill_done and enter READY in the following cycle.
REQ-018 Total words per fill SHALL be 11+2N.

Reset
REQ-019 On rst, the block SHALL enter INIT at ROM index 0 with cmd_wr=0, cmd_dout=0, ready=0, fill_done=0, fill_err=0, and the delay counter cleared.
REQ-020 Reset mid-fill or mid-delay SHALL abort immediately with no further writes, and init SHALL restart from index 0.

Configuration
REQ-021 Macro LCD_INIT_DELAY_EN:
- Defined: delay entries are honoured per REQ-010.
- Undefined: delay entries are skipped in one cycle with no write; all other behaviour is identical (fast simulation).

Structure
REQ-022 A shared package lcd_pkg SHALL hold:
- The state enum.
- Opcode constants CASET=0x2A, PASET=0x2B, RAMWR=0x2C.
- The ROM entry field positions and end marker 0x3FF.
REQ-023 The init table SHALL live in sub-module lcd_init_rom: combinational, 6-bit index in, 10-bit entry out.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, cmd_full=0, macro undefined -> FIFO receives exactly the non-delay ROM words in order; ready rises.
- Macro defined, ROM delay entry 5, DELAY_UNIT=10 -> 50-cycle gap with no cmd_wr at that point.
- Fill x0=3, x1=4, y0=0, y1=1, colour 0xF800 -> 0x02A,0x100,0x103,0x100,0x104, 0x02B,0x100,0x100,0x100,0x101, 0x02C, then 4×(0x1F8,0x100); fill_done pulses once.
- Same fill with cmd_full toggled randomly -> identical word sequence, no drops or duplicates.
- Request x0=10, x1=5 -> fill_err pulse, zero writes, ready stays 1. rst asserted mid-PIXEL -> writes stop, init restarts from index 0.
